// File: rtl/video_frame_meter.sv
// rtl/video_frame_meter.sv - pixel stream receive checker: per-frame width/height/checksum and protocol errors
// Inputs are registered once; the FSM runs on those samples and their previous values.
module video_frame_meter #(
   parameter int PIXEL_WIDTH = 8,
   parameter int CNT_WIDTH   = 16,
   parameter int SUM_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PIXEL_WIDTH-1:0] di_i,
   input  logic                   de_i,
   input  logic                   hs_i,
   input  logic                   vs_i,
   output logic [CNT_WIDTH-1:0]   frame_w_o,
   output logic [CNT_WIDTH-1:0]   frame_h_o,
   output logic [SUM_WIDTH-1:0]   frame_sum_o,
   output logic [CNT_WIDTH-1:0]   frame_cnt_o,
   output logic                   err_width_o,
   output logic                   err_blank_o,
   output logic                   frame_done_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_LINE  = 2'd2;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [1:0]             state_q, state_d;
   logic                   hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic [PIXEL_WIDTH-1:0] di_q, di_d;
   logic                   hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic [CNT_WIDTH-1:0]   pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, ref_w_q, ref_w_d;
   logic                   first_line_q, first_line_d;
   logic [SUM_WIDTH-1:0]   sum_q, sum_d;
   logic                   err_width_q, err_width_d, err_blank_q, err_blank_d;
   logic [CNT_WIDTH-1:0]   frame_w_q, frame_w_d, frame_h_q, frame_h_d, frame_cnt_q, frame_cnt_d;
   logic [SUM_WIDTH-1:0]   frame_sum_q, frame_sum_d;
   logic                   out_err_width_q, out_err_width_d, out_err_blank_q, out_err_blank_d;
   logic                   frame_done_q, frame_done_d;

   logic                   vs_rise, vs_fall, hs_rise, hs_fall, line_end, frame_end;
   logic [CNT_WIDTH-1:0]   pix_eff;
   logic [SUM_WIDTH-1:0]   di_ext;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
   endfunction

   always_comb begin
      hs_d            = hs_i;
      vs_d            = vs_i;
      de_d            = de_i;
      di_d            = di_i;
      hs_prev_d       = hs_q;
      vs_prev_d       = vs_q;
      state_d         = state_q;
      pix_cnt_d       = pix_cnt_q;
      line_cnt_d      = line_cnt_q;
      ref_w_d         = ref_w_q;
      first_line_d    = first_line_q;
      sum_d           = sum_q;
      err_width_d     = err_width_q;
      err_blank_d     = err_blank_q;
      frame_w_d       = frame_w_q;
      frame_h_d       = frame_h_q;
      frame_sum_d     = frame_sum_q;
      frame_cnt_d     = frame_cnt_q;
      out_err_width_d = out_err_width_q;
      out_err_blank_d = out_err_blank_q;
      frame_done_d    = 1'b0;
      vs_rise         = vs_q & ~vs_prev_q;
      vs_fall         = ~vs_q & vs_prev_q;
      hs_rise         = hs_q & ~hs_prev_q;
      hs_fall         = ~hs_q & hs_prev_q;
      line_end        = 1'b0;
      frame_end       = 1'b0;
      pix_eff         = pix_cnt_q;
      di_ext          = {{(SUM_WIDTH-PIXEL_WIDTH){1'b0}}, di_q};

      case (state_q)
         ST_IDLE: begin
            // A stray pixel outside a frame is charged to the frame that follows
            if (de_q) err_blank_d = 1'b1;
            if (vs_rise) begin
               pix_cnt_d    = '0;
               line_cnt_d   = '0;
               ref_w_d      = '0;
               first_line_d = 1'b0;
               sum_d        = '0;
               err_width_d  = 1'b0;
               state_d      = ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (vs_fall) begin
               frame_end = 1'b1;
            end else if (hs_fall) begin
               pix_cnt_d = de_q ? CNT_WIDTH'(1) : '0;
               if (de_q) sum_d = sum_q + di_ext;
               state_d = ST_LINE;
            end else if (de_q) begin
               err_blank_d = 1'b1;
            end
         end
         ST_LINE: begin
            if (vs_fall) begin
               line_end  = 1'b1;
               frame_end = 1'b1;
            end else begin
               if (de_q) begin
                  pix_eff   = sat_inc(pix_cnt_q);
                  pix_cnt_d = pix_eff;
                  sum_d     = sum_q + di_ext;
               end
               if (hs_rise) begin
                  line_end = 1'b1;
                  state_d  = ST_BLANK;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (line_end && pix_eff != '0) begin
         line_cnt_d = sat_inc(line_cnt_q);
         if (!first_line_q) begin
            ref_w_d      = pix_eff;
            first_line_d = 1'b1;
         end else if (pix_eff != ref_w_q) begin
            err_width_d = 1'b1;
         end
      end

      // Frame end sees the line-end results of the same sample
      if (frame_end) begin
         frame_w_d       = ref_w_d;
         frame_h_d       = line_cnt_d;
         frame_sum_d     = sum_d;
         out_err_width_d = err_width_d;
         out_err_blank_d = err_blank_d;
         frame_cnt_d     = sat_inc(frame_cnt_q);
         frame_done_d    = 1'b1;
         err_blank_d     = de_q;
         state_d         = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         hs_q            <= 1'b1;
         vs_q            <= 1'b0;
         de_q            <= 1'b0;
         di_q            <= '0;
         hs_prev_q       <= 1'b1;
         vs_prev_q       <= 1'b0;
         pix_cnt_q       <= '0;
         line_cnt_q      <= '0;
         ref_w_q         <= '0;
         first_line_q    <= 1'b0;
         sum_q           <= '0;
         err_width_q     <= 1'b0;
         err_blank_q     <= 1'b0;
         frame_w_q       <= '0;
         frame_h_q       <= '0;
         frame_sum_q     <= '0;
         frame_cnt_q     <= '0;
         out_err_width_q <= 1'b0;
         out_err_blank_q <= 1'b0;
         frame_done_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         hs_q            <= hs_d;
         vs_q            <= vs_d;
         de_q            <= de_d;
         di_q            <= di_d;
         hs_prev_q       <= hs_prev_d;
         vs_prev_q       <= vs_prev_d;
         pix_cnt_q       <= pix_cnt_d;
         line_cnt_q      <= line_cnt_d;
         ref_w_q         <= ref_w_d;
         first_line_q    <= first_line_d;
         sum_q           <= sum_d;
         err_width_q     <= err_width_d;
         err_blank_q     <= err_blank_d;
         frame_w_q       <= frame_w_d;
         frame_h_q       <= frame_h_d;
         frame_sum_q     <= frame_sum_d;
         frame_cnt_q     <= frame_cnt_d;
         out_err_width_q <= out_err_width_d;
         out_err_blank_q <= out_err_blank_d;
         frame_done_q    <= frame_done_d;
      end
   end

   assign frame_w_o    = frame_w_q;
   assign frame_h_o    = frame_h_q;
   assign frame_sum_o  = frame_sum_q;
   assign frame_cnt_o  = frame_cnt_q;
   assign err_width_o  = out_err_width_q;
   assign err_blank_o  = out_err_blank_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_video_frame_meter.sv
// tb/tb_video_frame_meter.sv - randomized frame stimulus checked against a line-list frame model
module tb_video_frame_meter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  di_i = '0;
   logic        de_i = 1'b0;
   logic        hs_i = 1'b1;
   logic        vs_i = 1'b0;
   logic [15:0] frame_w_o, frame_h_o, frame_cnt_o;
   logic [31:0] frame_sum_o;
   logic        err_width_o, err_blank_o, frame_done_o;

   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          exp_frames = 0;
   logic [15:0] cap_w, cap_h, cap_cnt;
   logic [31:0] cap_sum;
   logic        cap_ew, cap_eb;

   video_frame_meter dut (
      .clk(clk), .rst(rst), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
      .frame_w_o(frame_w_o), .frame_h_o(frame_h_o), .frame_sum_o(frame_sum_o),
      .frame_cnt_o(frame_cnt_o), .err_width_o(err_width_o), .err_blank_o(err_blank_o),
      .frame_done_o(frame_done_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done_o) begin
         done_cnt <= done_cnt + 1;
         cap_w    <= frame_w_o;
         cap_h    <= frame_h_o;
         cap_sum  <= frame_sum_o;
         cap_cnt  <= frame_cnt_o;
         cap_ew   <= err_width_o;
         cap_eb   <= err_blank_o;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic h, input logic v, input logic d, input logic [7:0] p);
      hs_i = h; vs_i = v; de_i = d; di_i = p;
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] pix(input int x, input int y, input int off);
      return 8'((x + y + off) & 255);
   endfunction

   function automatic int line_len(input int y, input int w, input int short_y);
      return (y == short_y) ? w - 1 : w;
   endfunction

   // gap >= 0: fixed idle cycles before each pixel; gap < 0: random 0..-gap
   task automatic drive_frame(input int nl, input int w, input int short_y, input int gap,
                              input int blank_y, input bit src_style, input int abort_y,
                              input int off);
      repeat (4) cyc(1, 0, 0, 0);
      repeat (5) cyc(1, 1, 0, 0);
      for (int y = 0; y < nl; y++) begin
         if (y == abort_y) begin
            rst = 1'b1;
            cyc(1, 0, 0, 0);
            cyc(1, 0, 0, 0);
            rst = 1'b0;
            repeat (4) cyc(1, 0, 0, 0);
            return;
         end
         for (int x = 0; x < line_len(y, w, short_y); x++) begin
            int g;
            g = (gap >= 0) ? gap : int'($urandom_range(0, -gap));
            repeat (g) cyc(0, 1, 0, 0);
            cyc(0, 1, 1, pix(x, y, off));
         end
         if (src_style && y == nl - 1) begin
            cyc(1, 0, 0, 0);
         end else begin
            for (int g = 0; g < 8; g++) cyc(1, 1, (y == blank_y && g == 3), 8'hAA);
         end
      end
      if (!src_style || nl == 0) repeat (3) cyc(1, 1, 0, 0);
      repeat (6) cyc(1, 0, 0, 0);
   endtask

   task automatic run_frame(input string tag, input int nl, input int w, input int short_y,
                            input int gap, input int blank_y, input bit src_style);
      int          base, off, ref_w, h, waited;
      bit          ew, eb;
      logic [31:0] sum;
      off = int'($urandom_range(0, 255));
      ref_w = 0; h = 0; ew = 0; sum = 0;
      for (int y = 0; y < nl; y++) begin
         int len;
         len = line_len(y, w, short_y);
         for (int x = 0; x < len; x++) sum = sum + 32'(pix(x, y, off));
         if (len > 0) begin
            if (h == 0) ref_w = len;
            else if (len != ref_w) ew = 1;
            h++;
         end
      end
      eb = (blank_y >= 0 && blank_y < nl && !(src_style && blank_y == nl - 1));
      base = done_cnt;
      drive_frame(nl, w, short_y, gap, blank_y, src_style, -1, off);
      waited = 0;
      while (done_cnt == base && waited < 20) begin
         cyc(1, 0, 0, 0);
         waited++;
      end
      exp_frames++;
      check({tag, "_done"}, 64'(done_cnt - base), 64'd1);
      check({tag, "_w"}, 64'(cap_w), 64'(ref_w));
      check({tag, "_h"}, 64'(cap_h), 64'(h));
      check({tag, "_sum"}, 64'(cap_sum), 64'(sum));
      check({tag, "_errw"}, 64'(cap_ew), 64'(ew));
      check({tag, "_errb"}, 64'(cap_eb), 64'(eb));
      check({tag, "_cnt"}, 64'(cap_cnt), 64'(exp_frames));
   endtask

   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_w", 64'(frame_w_o), 64'd0);
      check("rst_cnt", 64'(frame_cnt_o), 64'd0);
      check("rst_done", 64'(frame_done_o), 64'd0);
      check("rst_errs", 64'({err_width_o, err_blank_o}), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_frame("cont", 48, 64, -1, 0, -1, 0);
      run_frame("sparse", 48, 64, -1, 3, -1, 0);
      run_frame("short", 48, 64, 24, 0, -1, 0);
      run_frame("clean", 48, 64, -1, -2, -1, 0);
      run_frame("blank", 20, 32, -1, 0, 10, 0);
      run_frame("srcstyle", 30, 20, -1, -1, -1, 1);
      run_frame("noline", 0, 16, -1, 0, -1, 0);

      base = done_cnt;
      drive_frame(40, 24, -1, 0, -1, 0, 20, 0);
      exp_frames = 0;
      check("abort_done", 64'(done_cnt - base), 64'd0);
      check("abort_cnt", 64'(frame_cnt_o), 64'd0);
      run_frame("post1", 16, 16, -1, 0, -1, 0);
      run_frame("post2", 16, 16, -1, -1, -1, 0);

      for (int i = 0; i < 5; i++) begin
         int w, nl, sy;
         w  = int'($urandom_range(1, 40));
         nl = int'($urandom_range(1, 20));
         sy = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, nl - 1)) : -1;
         run_frame($sformatf("rnd%0d", i), nl, w, sy, -3, -1, i[0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
